mips_dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port. It replaces the zero-wait combinational data memory with a valid/ready request/response slave.
- Has a configurable fixed access latency and byte-lane writes, so a future multicycle or pipelined core can be checked against realistic memory timing.
- Holds the word-addressed data array internally and serves one outstanding transaction at a time.

---
 rtl/mips_dmem_responder.sv | 147 ++++++++++++++
 tb/tb_mips_dmem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// Valid/ready data-memory responder with fixed access latency and byte-lane stores.
// Define DMEM_RSP_ERR_EN to flag misaligned or out-of-range addresses with rsp_err.
module mips_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

`ifdef DMEM_RSP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // Byte-address bits that may legally be set: word-aligned, inside the array.
  localparam logic [31:0] LEGAL_MASK = 32'(DEPTH_WORDS * 4 - 1) & 32'hFFFF_FFFC;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept, commit;

  logic             lat_write;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_be;

  logic             cur_write;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_err;

  // Next-state and counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            commit     = 1'b1;
            state_next = S_RESP;
          end else begin
            cnt_next   = CNT_W'(LATENCY - 1);
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          commit     = 1'b1;
          cnt_next   = '0;
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // With LATENCY==1 the commit happens on the accept edge, before the latch is loaded.
  always_comb begin
    cur_write = lat_write;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == S_IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
    cur_idx = cur_addr[IDX_W+1:2];
    cur_err = ERR_EN & (|(cur_addr & ~LEGAL_MASK));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == S_IDLE);
      rsp_valid <= (state_next == S_RESP);
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (commit) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_write || cur_err) ? 32'h0 : mem[cur_idx];
      end else if (state == S_RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Array is deliberately not reset; a reset in the commit cycle drops the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_write && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: a LATENCY=2 instance for function,
// plus a LATENCY=1 instance for back-to-back timing.
module tb_mips_dmem_responder;

  localparam int unsigned LAT_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int n_checks = 0;
  int n_pass   = 0;

  mips_dmem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT_A)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mips_dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present a request on instance A and wait (bounded) for the response.
  task automatic a_issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check($sformatf("%s_rdy", tag), 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check($sformatf("%s_lat", tag), 32'(n), 32'(LAT_A));
  endtask

  task automatic a_finish(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("%s_idle", tag), 32'({rsp_valid, req_ready, rsp_err}), 32'h2);
  endtask

  task automatic a_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                        input string tag);
    a_issue(wr, addr, wdata, be, tag);
    check($sformatf("%s_rdata", tag), rsp_rdata, exp_rdata);
    check($sformatf("%s_err", tag), 32'(rsp_err), 32'(exp_err));
    a_finish(tag);
  endtask

  // LATENCY=1 instance: response must be visible right after the accept edge.
  task automatic b_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input string tag, output int acc);
    int n;
    n = 0;
    while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
    b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata; b_req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    acc = cyc;
    check($sformatf("%s_valid", tag), 32'({b_rsp_valid, b_req_ready}), 32'h2);
    check($sformatf("%s_rdata", tag), b_rsp_rdata, exp_rdata);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc0, acc1, acc2;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_ctl", 32'({req_ready, rsp_valid, rsp_err}), 32'h4);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_ctl_b", 32'({b_req_ready, b_rsp_valid, b_rsp_err}), 32'h4);

    // Store then load
    a_xfer(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st08");
    a_xfer(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld08");

    // Byte lanes, then an all-lanes-off store that must write nothing
    a_xfer(1'b1, 32'h10, 32'h11223344, 4'hF, 32'h0, 1'b0, "pre10");
    a_xfer(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, "be10");
    a_xfer(1'b0, 32'h10, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, "ld10");
    a_xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "be0");
    a_xfer(1'b0, 32'h10, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, "ld10b");

    // Backpressure: response held for 5 cycles with rsp_ready low
    a_issue(1'b0, 32'h08, 32'h0, 4'hF, "bp");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_ctl", i), 32'({rsp_valid, req_ready, rsp_err}), 32'h4);
      check($sformatf("bp_hold%0d_rdata", i), rsp_rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    a_finish("bp");

    // Reset during WAIT drops the store
    a_xfer(1'b1, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0, "pre04");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h04; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_wait", 32'({rsp_valid, req_ready}), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_after", 32'({rsp_valid, req_ready}), 32'h1);
    a_xfer(1'b0, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0, "ld04");

    // Out-of-range, misaligned address
    a_xfer(1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "pre00");
`ifdef DMEM_RSP_ERR_EN
    a_xfer(1'b0, 32'h102, 32'h0, 4'hF, 32'h0, 1'b1, "ld102");
`else
    a_xfer(1'b0, 32'h102, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, "ld102");
`endif

    // LATENCY=1 instance: back-to-back loads at a 2-cycle period
    b_xfer(1'b1, 32'h20, 32'h12345678, 32'h0, "b_st20", acc0);
    b_xfer(1'b0, 32'h20, 32'h0, 32'h12345678, "b_ld20a", acc1);
    b_xfer(1'b0, 32'h20, 32'h0, 32'h12345678, "b_ld20b", acc2);
    check("b_period", 32'(acc2 - acc1), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
